// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main control FSM (Moore, memory-ready handshake).
// Optional BNE support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_ctrl_fsm #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    RTEX   = STATE_W'(6),
    RTWB   = STATE_W'(7),
    BEQEX  = STATE_W'(8),
    ADDIEX = STATE_W'(9),
    ADDIWB = STATE_W'(10),
`ifdef MIPS_CTRL_BNE_EN
    BNEEX  = STATE_W'(12),
`endif
    JEX    = STATE_W'(11)
  } state_t;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
`endif

  state_t cur, nxt;
  logic   pcwrite, branch, bne;

  always_ff @(posedge clk) begin
    if (!rst) cur <= FETCH;
    else      cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt        = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    // In reset the muxes show FETCH selects while every enable stays low.
    if (!rst) begin
      alusrcb = 2'b01;
    end else begin
      case (cur)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          nxt     = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alusrcb = 2'b11;
          if (op == OP_LW || op == OP_SW) nxt = MEMADR;
          else if (op == OP_RTYP)         nxt = RTEX;
          else if (op == OP_BEQ)          nxt = BEQEX;
          else if (op == OP_ADDI)         nxt = ADDIEX;
          else if (op == OP_J)            nxt = JEX;
`ifdef MIPS_CTRL_BNE_EN
          else if (op == OP_BNE)          nxt = BNEEX;
`endif
          else                            illegal_op = 1'b1;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          nxt     = (op == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          iord = 1'b1;
          nxt  = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
          nxt      = mem_ready ? FETCH : MEMWR;
        end
        RTEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          nxt     = RTWB;
        end
        RTWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BEQEX: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          nxt     = ADDIWB;
        end
        ADDIWB: regwrite = 1'b1;
        JEX: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
`ifdef MIPS_CTRL_BNE_EN
        BNEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          bne     = 1'b1;
        end
`endif
        default: nxt = FETCH;
      endcase
    end
    pcen = pcwrite | (branch & zero) | (bne & ~zero);
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Table-driven bench for mips_ctrl_fsm; expected output words go through a scoreboard queue.
module tb_mips_ctrl_fsm;
  logic       clk, rst, zero, mem_ready;
  logic [5:0] op;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal_op;
  logic [3:0] state;

  mips_ctrl_fsm #(.STATE_W(4), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en  = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca}
  // mux = {alusrcb, aluop, pcsrc};  fl = {pcen, illegal_op}
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mr;
    logic [3:0] st;
    logic [6:0] en;
    logic [5:0] mux;
    logic [1:0] fl;
  } vec_t;

  vec_t          vecs[$];
  logic [18:0]   sb[$];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic vec_t mkv(logic r, logic [5:0] o, logic z, logic m,
                               logic [3:0] s, logic [6:0] e, logic [5:0] x, logic [1:0] f);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = m;
    v.st = s; v.en = e; v.mux = x; v.fl = f;
    return v;
  endfunction

  function automatic logic [18:0] dut_word();
    return {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, aluop, pcsrc, pcen, illegal_op};
  endfunction

  task automatic step(input vec_t v, input string nm);
    logic [18:0] exp, act;
    @(posedge clk); #1;
    rst = v.rst; op = v.op; zero = v.zero; mem_ready = v.mr;
    sb.push_back({v.st, v.en, v.mux, v.fl});
    @(negedge clk);
    exp = sb.pop_front();
    act = dut_word();
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d en=%b mux=%b fl=%b, expected st=%0d en=%b mux=%b fl=%b",
               nm, act[18:15], act[14:8], act[7:2], act[1:0],
               exp[18:15], exp[14:8], exp[7:2], exp[1:0]);
    end
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         J = 6'b000010, RT = 6'b000000, ADDI = 6'b001000, BNE = 6'b000101;

  initial begin
    bit got;
    rst = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;

    // reset held, then lw
    vecs.push_back(mkv(0, LW, 0, 1, 0, 7'b0000000, 6'b010000, 2'b00));
    vecs.push_back(mkv(0, LW, 0, 1, 0, 7'b0000000, 6'b010000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, LW, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 2, 7'b0000001, 6'b100000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 3, 7'b1000000, 6'b000000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 4, 7'b0000110, 6'b000000, 2'b00));
    // sw with 3 wait cycles in MEMWR
    vecs.push_back(mkv(1, SW, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, SW, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, SW, 0, 1, 2, 7'b0000001, 6'b100000, 2'b00));
    vecs.push_back(mkv(1, SW, 0, 0, 5, 7'b1100000, 6'b000000, 2'b00));
    vecs.push_back(mkv(1, SW, 0, 0, 5, 7'b1100000, 6'b000000, 2'b00));
    vecs.push_back(mkv(1, SW, 0, 0, 5, 7'b1100000, 6'b000000, 2'b00));
    vecs.push_back(mkv(1, SW, 0, 1, 5, 7'b1100000, 6'b000000, 2'b00));
    // FETCH stall, then beq taken and not taken
    vecs.push_back(mkv(1, BEQ, 1, 0, 0, 7'b0000000, 6'b010000, 2'b00));
    vecs.push_back(mkv(1, BEQ, 1, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, BEQ, 1, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, BEQ, 1, 1, 8, 7'b0000001, 6'b000101, 2'b10));
    vecs.push_back(mkv(1, BEQ, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, BEQ, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, BEQ, 0, 1, 8, 7'b0000001, 6'b000101, 2'b00));
    // j, R-type, addi
    vecs.push_back(mkv(1, J, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, J, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, J, 0, 1, 11, 7'b0000000, 6'b000010, 2'b10));
    vecs.push_back(mkv(1, RT, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, RT, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, RT, 0, 1, 6, 7'b0000001, 6'b001000, 2'b00));
    vecs.push_back(mkv(1, RT, 0, 1, 7, 7'b0001010, 6'b000000, 2'b00));
    vecs.push_back(mkv(1, ADDI, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, ADDI, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, ADDI, 0, 1, 9, 7'b0000001, 6'b100000, 2'b00));
    vecs.push_back(mkv(1, ADDI, 0, 1, 10, 7'b0000010, 6'b000000, 2'b00));
    // op 000101
    vecs.push_back(mkv(1, BNE, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
`ifdef MIPS_CTRL_BNE_EN
    vecs.push_back(mkv(1, BNE, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 12, 7'b0000001, 6'b000101, 2'b10));
`else
    vecs.push_back(mkv(1, BNE, 0, 1, 1, 7'b0000000, 6'b110000, 2'b01));
`endif
    // reset asserted in MEMADR of an lw
    vecs.push_back(mkv(1, LW, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));
    vecs.push_back(mkv(1, LW, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00));
    vecs.push_back(mkv(0, LW, 0, 1, 2, 7'b0000000, 6'b010000, 2'b00));
    vecs.push_back(mkv(1, LW, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // lw stalled in MEMRD, then bounded wait for MEMWB once memory is ready
    step(mkv(1, LW, 0, 1, 1, 7'b0000000, 6'b110000, 2'b00), "stall_decode");
    step(mkv(1, LW, 0, 0, 2, 7'b0000001, 6'b100000, 2'b00), "stall_memadr");
    for (int k = 0; k < 3; k++)
      step(mkv(1, LW, 0, 0, 3, 7'b1000000, 6'b000000, 2'b00), $sformatf("stall_memrd%0d", k));
    @(posedge clk); #1; mem_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (state == 4'd4) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL memwb_wait: state=%0d, required 4 within 8 cycles", state);
    end
    step(mkv(1, LW, 0, 1, 0, 7'b0010000, 6'b010000, 2'b10), "after_memwb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mips_ctrl_fsm.md
Name: mips_ctrl_fsm

Overview:
Multicycle MIPS main control FSM. It drives the select lines of the datapath mux4 instances: alusrcb[1:0] into the ALU-B mux4 and pcsrc[1:0] into the next-PC mux4. It also drives every datapath write enable. Moore machine with a memory-ready handshake. It sits between the instruction register (op field) and the datapath muxes and registers.

Parameters:
STATE_W, 4, width of state register and debug port (must be >= 4)
OP_W, 6, opcode width (fixed by ISA; exposed for bench readability only)

Ports:
clk  input  1  clock, all state changes on posedge
rst  input  1  reset, synchronous, active-low
op  input  OP_W  instruction opcode instr[31:26]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes read/write this cycle
iord  output  1  memory address mux: 0 PC, 1 ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  write register: 0 rt, 1 rd
memtoreg  output  1  write data: 0 ALUOut, 1 data reg
regwrite  output  1  register file write
alusrca  output  1  ALU A: 0 PC, 1 reg A
alusrcb  output  2  ALU B mux4: 00 B, 01 const 4, 10 signimm, 11 signimm<<2
aluop  output  2  00 add, 01 sub, 10 funct decode
pcsrc  output  2  next-PC mux4: 00 ALUResult, 01 ALUOut, 10 jump target, 11 unused (never driven)
pcen  output  1  PC load
illegal_op  output  1  one-cycle pulse on unsupported opcode
state  output  STATE_W  current state (debug)

Behaviour:
- State register updates on posedge clk. When rst==0 at an edge, state <= FETCH.
- While rst==0, the outputs irwrite, memwrite, regwrite, pcen and illegal_op are forced to 0 combinationally. All other outputs take their FETCH values.
- Outputs are a combinational decode of state, plus mem_ready and zero where noted. Any output not listed for a state is 0.
- State encoding is fixed:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12
- Per-state outputs and transitions:
  - FETCH: alusrcb=01. irwrite=pcwrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alusrcb=11. Next state by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - anything else -> FETCH, with illegal_op=1 during DECODE.
  - MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: memtoreg=1, regwrite=1. Goes to FETCH.
  - MEMWR: iord=1, memwrite=1. memwrite stays asserted while waiting. Goes to FETCH when mem_ready=1.
  - RTEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTWB.
  - RTWB: regdst=1, regwrite=1. Goes to FETCH.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10. Goes to ADDIWB.
  - ADDIWB: regwrite=1. Goes to FETCH.
  - JEX: pcsrc=10, pcwrite=1. Goes to FETCH.
- pcen = pcwrite | (branch & zero) | (bne & ~zero).
- Instruction latencies, assuming mem_ready is tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Reset asserted mid-instruction: the FSM returns to FETCH at the next edge. No write enable is asserted during the reset cycle.
- An unreachable encoding (13-15) goes to FETCH on the next edge with all enables 0.

Optional Feature:
MIPS_CTRL_BNE_EN
- Defined: op 000101 in DECODE goes to BNEEX. BNEEX drives alusrca=1, aluop=01, pcsrc=01, bne=1, then goes to FETCH.
- Undefined: state 12 does not exist and bne is tied to 0. Op 000101 is illegal and pulses illegal_op.

Test Plan:
1. rst=0 held 2 cycles, then rst=1, mem_ready=1 -> state=0, irwrite=pcen=0 during reset; first FETCH cycle gives irwrite=pcen=1, alusrcb=01, pcsrc=00.
2. lw (op=100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; in MEMWB regwrite=1, memtoreg=1, regdst=0.
3. sw (op=101011), mem_ready held 0 for 3 cycles in MEMWR -> state stays 5 for 4 cycles with memwrite=1 throughout; then FETCH; regwrite never 1.
4. beq (op=000100) with zero=1, then repeated with zero=0 -> in BEQEX pcsrc=01, aluop=01; pcen=1 for the zero=1 run, pcen=0 for the zero=0 run.
5. j (op=000010) -> sequence 0,1,11,0; in JEX pcsrc=10, pcen=1. R-type (op=000000) -> 0,1,6,7,0 with alusrcb=00, aluop=10, then regdst=1.
6. op=000101 -> illegal_op=1 for 1 cycle and return to FETCH without the macro; with MIPS_CTRL_BNE_EN defined and zero=0 -> state 12, pcen=1.
